// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the fetch/decode front end.
package rv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Major opcodes in out_instr[6:0]; decode and the immediate extender
  // select their format from these.
  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_FENCE  = 7'b0001111,
    OP_SYSTEM = 7'b1110011
  } opcode_e;

  // One buffered fetch: the word and the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_buffer_fetch_fifo.sv
// In-order buffer of {pc, instr} entries between fetch and decode.
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int unsigned  DEPTH       = 2,
  parameter fetch_entry_t RESET_ENTRY = '{pc: RESET_PC_DEFAULT, instr: NOP_INSTR}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  fetch_entry_t             i_push_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output fetch_entry_t             o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t   r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;

  logic           w_do_pop;
  logic           w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop && !o_empty;
  // A push into a full buffer is only accepted when the head leaves the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Entry storage; the head shows a NOP at its reset PC until the first push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= RESET_ENTRY;
      end
    end else if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers and occupancy; flush empties the buffer regardless of push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/instr_fetch_buffer.sv
// RV32I fetch stage: PC, request issue, response tracking and decode buffer.
module instr_fetch_buffer
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [XLEN-1:0]  imem_rdata,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_instr,
  output logic [XLEN-1:0]  out_pc
);

  localparam int unsigned  CW = $clog2(DEPTH) + 1;
  localparam fetch_entry_t L_RESET_ENTRY = '{pc: RESET_PC, instr: NOP_INSTR};

  logic [XLEN-1:0] r_pc;       // next fetch address
  logic [XLEN-1:0] r_resp_pc;  // PC owed to the next kept response
  logic [CW-1:0]   r_pend;     // issued, not yet returned
  logic [CW-1:0]   r_drop;     // returns still owed to a flushed stream

  fetch_entry_t    w_head;
  fetch_entry_t    w_push_data;
  logic [CW-1:0]   w_fifo_count;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_issue;
  logic            w_resp;
  logic            w_push;
  logic [CW:0]     w_occupancy;
  logic [XLEN-1:0] w_target;

  assign w_target    = word_align(redirect_pc);
  assign out_valid   = !w_empty;
  assign out_instr   = w_head.instr;
  assign out_pc      = w_head.pc;
  assign imem_addr   = r_pc;

  assign w_pop       = out_valid && out_ready && !redirect;
  assign w_issue     = imem_req && imem_gnt;
  // Returns with nothing outstanding are a protocol error and are ignored.
  assign w_resp      = imem_rvalid && (r_pend != '0);
  assign w_push      = w_resp && (r_drop == '0) && !redirect;
  assign w_push_data = '{pc: r_resp_pc, instr: imem_rdata};

  // A slot freed by this cycle's pop counts as free, so a 1-cycle memory
  // streams one word per cycle with DEPTH=2; a response needs >=1 cycle,
  // so the slot is already vacated when the word arrives.
  assign w_occupancy = {1'b0, w_fifo_count} + {1'b0, r_pend} - (CW+1)'(w_pop);

  // Issue whenever every outstanding and buffered word fits in the buffer.
  always_comb begin
    imem_req = 1'b0;
    if (!reset && !redirect && !(w_full && !w_pop)) begin
      imem_req = (w_occupancy < (CW+1)'(DEPTH));
    end
  end

  // Fetch PC and the PC tag for the next kept response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_resp_pc <= RESET_PC;
    end else if (redirect) begin
      r_pc      <= w_target;
      r_resp_pc <= w_target;
    end else begin
      if (w_issue) begin
        r_pc <= r_pc + 32'd4;
      end
      if (w_push) begin
        r_resp_pc <= r_resp_pc + 32'd4;
      end
    end
  end

  // Outstanding and stale-return counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend <= '0;
      r_drop <= '0;
    end else begin
      if (w_issue && !w_resp) begin
        r_pend <= r_pend + CW'(1);
      end else if (!w_issue && w_resp) begin
        r_pend <= r_pend - CW'(1);
      end
      // Everything still outstanding after a redirect belongs to the old stream.
      if (redirect) begin
        r_drop <= r_pend - CW'(w_resp);
      end else if (w_resp && (r_drop != '0)) begin
        r_drop <= r_drop - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH       (DEPTH),
    .RESET_ENTRY (L_RESET_ENTRY)
  ) u_fifo (
    .clk         (clk),
    .rst         (reset),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (redirect),
    .o_head      (w_head),
    .o_count     (w_fifo_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: in-order memory model plus decode scoreboard.
module tb_instr_fetch_buffer;

  localparam int unsigned DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  always #5 clk = ~clk;

  instr_fetch_buffer #(
    .RESET_PC (RST_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned epoch;
    int unsigned due;
  } mreq_t;

  int unsigned checks = 0;
  int unsigned errors = 0;
  mreq_t       mq[$];       // requests accepted by memory, in issue order
  logic [63:0] exq[$];      // expected {pc, instr} stream to decode
  logic [31:0] pop_log[$];  // PCs popped by decode
  int unsigned cyc = 0;
  int unsigned epoch = 0;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;
  int unsigned nissue;
  logic [31:0] exp_addr;
  logic        s_req, s_valid, s_rvalid, s_issue;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5B;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, observe, update model.
  task automatic step(input logic rdy, input logic gnt, input logic redir, input logic [31:0] rpc);
    logic [63:0] e;
    mreq_t       m;
    @(negedge clk);
    out_ready   = rdy;
    imem_gnt    = gnt;
    redirect    = redir;
    redirect_pc = rpc;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mq[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = out_valid;
    s_pc = out_pc; s_instr = out_instr; s_rvalid = imem_rvalid;
    s_issue = imem_req && imem_gnt;
    chk("out_valid", out_valid, (exq.size() != 0));
    if (out_valid && out_ready && !redirect && exq.size() != 0) begin
      e = exq.pop_front();
      chk("pop_pc", out_pc, e[63:32]);
      chk("pop_instr", out_instr, e[31:0]);
      pop_log.push_back(out_pc);
    end
    if (s_issue) begin
      chk("issue_addr", imem_addr, exp_addr);
      m.addr = imem_addr; m.epoch = epoch; m.due = cyc + $urandom_range(lat_max, lat_min);
      mq.push_back(m);
      exp_addr = exp_addr + 32'd4;
    end
    if (imem_rvalid) begin
      m = mq.pop_front();
      if (m.epoch == epoch && !redirect) exq.push_back({m.addr, mem_word(m.addr)});
    end
    if (redirect) begin
      epoch++;
      exq.delete();
      exp_addr = {rpc[31:2], 2'b00};
    end
    chk("no_overissue", 32'(mq.size() + exq.size() <= DEPTH), 32'd1);
    cyc++;
  endtask

  // Reset asserted asynchronously mid-cycle; memory is reset along with the core.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_imem_addr", imem_addr, RST_PC);
    chk("rst_imem_req", imem_req, 1'b0);
    mq.delete(); exq.delete(); epoch++; exp_addr = RST_PC;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0; exp_addr = RST_PC;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_req", imem_req, 1'b0);
    chk("reset_addr", imem_addr, RST_PC);
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_instr", out_instr, 32'h0000_0013);
    chk("reset_pc", out_pc, RST_PC);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1-cycle memory, decode always ready: one word per cycle from t+2.
    lat_min = 1; lat_max = 1;
    step(1, 1, 0, 0);
    chk("t0_req", s_req, 1'b1);
    chk("t0_addr", s_addr, 32'h0);
    step(1, 1, 0, 0);
    chk("t1_valid", s_valid, 1'b0);
    step(1, 1, 0, 0);
    chk("t2_valid", s_valid, 1'b1);
    chk("t2_pc", s_pc, 32'h0);
    chk("t2_instr", s_instr, mem_word(32'h0));
    step(1, 1, 0, 0);
    chk("t3_pc", s_pc, 32'h4);
    step(1, 1, 0, 0);
    chk("t4_pc", s_pc, 32'h8);

    // Decode stalled for 10 cycles: exactly DEPTH issues, head holds.
    do_reset();
    nissue = 0;
    repeat (10) begin
      step(0, 1, 0, 0);
      nissue += 32'(s_issue);
    end
    chk("stall_issues", nissue, DEPTH);
    chk("stall_req", s_req, 1'b0);
    chk("stall_head_pc", s_pc, 32'h0);
    chk("stall_valid", s_valid, 1'b1);
    pop_log.delete();
    repeat (8) step(1, 1, 0, 0);
    chk("release_pop0", pop_log[0], 32'h0);
    chk("release_pop1", pop_log[1], 32'h4);
    chk("release_pop2", pop_log[2], 32'h8);

    // Redirect with two responses outstanding: both are discarded.
    do_reset();
    lat_min = 4; lat_max = 4;
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    pop_log.delete();
    step(1, 1, 1, 32'h0000_1003);
    step(1, 1, 0, 0);
    chk("redir_valid_next", s_valid, 1'b0);
    chk("redir_addr_next", s_addr, 32'h0000_1000);
    repeat (12) step(1, 1, 0, 0);
    chk("redir_first_pc", pop_log[0], 32'h0000_1000);
    chk("redir_second_pc", pop_log[1], 32'h0000_1004);

    // Redirect coinciding with a response and a pop.
    do_reset();
    lat_min = 1; lat_max = 1;
    repeat (6) step(1, 1, 0, 0);
    pop_log.delete();
    step(1, 1, 1, 32'h0000_2000);
    chk("same_cyc_valid", s_valid, 1'b1);
    chk("same_cyc_rvalid", s_rvalid, 1'b1);
    step(1, 1, 0, 0);
    chk("same_cyc_valid_next", s_valid, 1'b0);
    chk("same_cyc_req_next", s_req, 1'b1);
    chk("same_cyc_addr_next", s_addr, 32'h0000_2000);
    repeat (4) step(1, 1, 0, 0);
    chk("same_cyc_first_pc", pop_log[0], 32'h0000_2000);

    // Random grant, latency and decode backpressure with sporadic redirects.
    do_reset();
    lat_min = 1; lat_max = 4;
    repeat (400) begin
      if ($urandom_range(99, 0) < 4)
        step(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b1, $urandom);
      else
        step(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b0, 32'h0);
    end

    // Address wrap at the top of memory.
    lat_min = 1; lat_max = 1;
    pop_log.delete();
    step(1, 1, 1, 32'hFFFF_FFF6);
    repeat (10) step(1, 1, 0, 0);
    chk("wrap_pop0", pop_log[0], 32'hFFFF_FFF4);
    chk("wrap_pop1", pop_log[1], 32'hFFFF_FFF8);
    chk("wrap_pop2", pop_log[2], 32'hFFFF_FFFC);
    chk("wrap_pop3", pop_log[3], 32'h0000_0000);

    // Reset asserted while the stream is flowing.
    step(1, 1, 0, 0);
    chk("pre_reset_valid", s_valid, 1'b1);
    do_reset();
    pop_log.delete();
    repeat (5) step(1, 1, 0, 0);
    chk("post_reset_pc", pop_log[0], RST_PC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_buffer.md
# instr_fetch_buffer

Fetch stage of the RV32I core: holds the program counter, issues word fetches to instruction memory over a request/grant port and buffers returned words with their PCs in a small in-order queue. Decode consumes `out_instr`/`out_pc` over a valid/ready handshake. `out_instr[31:7]` is the 25-bit field handed to the immediate extender, and `out_instr[6:0]` drives its format select. A `redirect` from branch/jump resolution flushes everything in flight and restarts fetch at the new target.

## Interface
- `RESET_PC`, 32'h0000_0000: PC of the first fetch after reset.
- `DEPTH`, 2: buffer entries; power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: word address (bits[1:0] always 0).
- `imem_gnt` in 1: request accepted this cycle (`imem_req && imem_gnt` = issue).
- `imem_rvalid` in 1: response valid; responses return in issue order, ≥1 cycle after issue.
- `imem_rdata` in 32: fetched instruction.
- `redirect` in 1: flush and restart.
- `redirect_pc` in 32: new fetch PC; bits[1:0] forced to 0.
- `out_valid` out 1: buffered instruction available.
- `out_ready` in 1: decode accepts (`out_valid && out_ready` = pop).
- `out_instr` out 32: head instruction.
- `out_pc` out 32: PC of head instruction.

## Operation
- Registers: `pc` (next fetch address), `pend` (issued, unreturned count, 0..DEPTH), `drop` (stale responses to discard, 0..DEPTH), FIFO of {pc, instr}.
- Issue rule: `imem_req = !reset && !redirect && (fifo_count + pend < DEPTH)`. No over-issue: every accepted response has a guaranteed slot.
- On issue: `pc <= pc + 4` (32-bit wrap, 0xFFFF_FFFC → 0), `pend++`. Issue PC is pushed into a PC side queue (part of FIFO entry, filled on response).
- Response with `drop == 0`: push {issued pc, `imem_rdata`}, `pend--`. With `drop > 0`: discard, `drop--`, `pend--`.
- Redirect (highest priority): FIFO flushed, `pc <= {redirect_pc[31:2],2'b00}`, `drop <= pend` (+1 if a response arrives the same cycle is not counted; the arriving response is itself discarded), `imem_req` forced 0 that cycle. A pop in the same cycle is ignored (entry already flushed, `out_valid` was for the old stream; decode must also squash).
- Simultaneous push and pop when full: legal, count unchanged.
- Out of range: `imem_rvalid` with `pend == 0` is a protocol error; ignored, assertion in bench.
- Reset mid-operation: all state cleared immediately; outstanding responses after reset release are not tracked, so memory must be reset with the core.

## Timing
- Reset values: `imem_req` 0, `imem_addr` RESET_PC, `out_valid` 0, `out_instr` 32'h0000_0013 (NOP), `out_pc` RESET_PC, `pend` 0, `drop` 0.
- First `imem_req` in the first cycle after `reset` deasserts.
- Response at edge N → `out_valid` high after edge N (registered; no rdata→out bypass).
- 1-cycle memory, `out_ready` held high: grant at t, rvalid at t+1, `out_valid` at t+2; sustained throughput 1 instr/cycle with DEPTH=2.
- Redirect asserted at cycle t → `out_valid` 0 at t+1, `imem_req` to target at t+1.
- `out_instr`/`out_pc` stable while `out_valid && !out_ready`.

## Structure
- Shared package `rv_pkg`: `XLEN=32`, `NOP_INSTR=32'h0000_0013`, `RESET_PC_DEFAULT`, opcode constants used by decode/extender select.
- Sub-module `fetch_fifo`: synchronous FIFO, DEPTH×64 ({pc,instr}), push/pop/flush, count output, full/empty.
- Top holds pc, pend, drop counters and issue logic; ≈200 lines total.

## Test plan
- Reset release, 1-cycle memory, `out_ready`=1 → `out_pc` sequence 0x0,0x4,0x8 on consecutive cycles from t+2, matching `imem_rdata`.
- `out_ready`=0 for 10 cycles → exactly DEPTH issues, `imem_req` low thereafter, head holds PC 0x0; release → no loss or duplicate.
- Redirect to 0x0000_1003 with 2 responses pending → both discarded, next `out_pc`=0x0000_1000.
- Redirect in same cycle as `imem_rvalid` and a pop → response dropped, `out_valid` 0 next cycle, fetch at target.
- Random `imem_gnt`/latency 1–4 cycles and `out_ready` → scoreboard: in-order, PC=prev+4 between redirects; PC 0xFFFF_FFFC wraps to 0x0.
- Assert `reset` mid-stream → `out_valid` 0 and `imem_addr`=RESET_PC in the same cycle.
